// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions.
package functions_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/nn_stream_pkg.sv
// Common types for the pixel-stream blocks of the network datapath.
package nn_stream_pkg;

  localparam int NN_CH_NUM     = 128;
  localparam int NN_DATA_WIDTH = 8;

  typedef logic [NN_CH_NUM-1:0][NN_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } upsample_state_t;

endpackage

// File: rtl/line_mem.sv
// Simple dual-port row buffer with a registered one-cycle read.
module line_mem #(
  parameter int DEPTH = 224,
  parameter int WIDTH = 1024,
  parameter int AW    = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/upsample_nn.sv
// Nearest-neighbour upsampler: each input pixel becomes a scale x scale block.
// Define UPSAMPLE_ZERO_FILL_EN for zero-insertion (only the top-left copy carries data).
module upsample_nn
  import functions_pkg::*;
  import nn_stream_pkg::*;
#(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int SCALE_MAX   = 4,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int CH_NUM      = NN_CH_NUM
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [clog2(FRAME_H_MAX):0]       frame_h,
  input  logic [clog2(FRAME_W_MAX):0]       frame_w,
  input  logic [clog2(SCALE_MAX):0]         scale,
  input  logic                              frame_start,
  input  logic                              din_vld,
  output logic                              din_rdy,
  input  logic [CH_NUM*DATA_WIDTH-1:0]      din,
  output logic                              dout_start,
  output logic                              dout_vld,
  output logic [CH_NUM*DATA_WIDTH-1:0]      dout
);

  localparam int HW = clog2(FRAME_H_MAX) + 1;
  localparam int WW = clog2(FRAME_W_MAX) + 1;
  localparam int SW = clog2(SCALE_MAX) + 1;
  localparam int AW = clog2(FRAME_W_MAX);
  localparam int PW = CH_NUM * DATA_WIDTH;

  upsample_state_t state_q, state_d;
  logic [HW-1:0] h_last_q, h_last_d, row_q, row_d;
  logic [WW-1:0] w_last_q, w_last_d, col_q, col_d;
  logic [SW-1:0] s_last_q, s_last_d, rep_q, rep_d, pass_q, pass_d;
  logic          prime_q, prime_d, first_q, first_d;
  logic          dout_vld_q, dout_vld_d, dout_start_q, dout_start_d;
  logic [PW-1:0] dout_q, dout_d, rd_data;
  logic          mem_we, emit, col_done, row_done, col_last, rep_last;

  line_mem #(
    .DEPTH (FRAME_W_MAX),
    .WIDTH (PW),
    .AW    (AW)
  ) u_line_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (col_q[AW-1:0]),
    .wdata_i (din),
    .raddr_i (col_d[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    h_last_d     = h_last_q;
    w_last_d     = w_last_q;
    s_last_d     = s_last_q;
    row_d        = row_q;
    col_d        = col_q;
    rep_d        = rep_q;
    pass_d       = pass_q;
    prime_d      = prime_q;
    first_d      = first_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    dout_start_d = 1'b0;
    din_rdy      = 1'b0;
    mem_we       = 1'b0;
    emit         = 1'b0;
    col_done     = 1'b0;
    row_done     = 1'b0;
    col_last     = (col_q == w_last_q);
    rep_last     = (rep_q == s_last_q);

    case (state_q)
      FIRST: begin
        if (rep_q == '0) begin
          din_rdy = !frame_start;
          if (din_vld && !frame_start) begin
            mem_we = 1'b1;
            emit   = 1'b1;
            dout_d = din;
          end
        end else begin
          emit = 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
          dout_d = '0;
`else
          dout_d = dout_q;
`endif
        end
        if (emit) begin
          if (rep_last) begin
            rep_d    = '0;
            col_done = 1'b1;
          end else begin
            rep_d = rep_q + SW'(1);
          end
        end
        if (col_done) begin
          if (col_last) begin
            col_d = '0;
            if (s_last_q == '0) begin
              row_done = 1'b1;
            end else begin
              state_d = REPEAT;
              prime_d = 1'b1;
              pass_d  = SW'(1);
            end
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end
      REPEAT: begin
        // The read address tracks col_d, so rd_data always holds the column being replayed.
        if (prime_q) begin
          prime_d = 1'b0;
        end else begin
          emit = 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
          dout_d = '0;
`else
          dout_d = rd_data;
`endif
          if (rep_last) begin
            rep_d = '0;
            if (col_last) begin
              col_d = '0;
              if (pass_q == s_last_q) begin
                pass_d   = '0;
                row_done = 1'b1;
              end else begin
                pass_d = pass_q + SW'(1);
              end
            end else begin
              col_d = col_q + WW'(1);
            end
          end else begin
            rep_d = rep_q + SW'(1);
          end
        end
      end
      default: ;
    endcase

    if (row_done) begin
      if (row_q == h_last_q) begin
        row_d   = '0;
        state_d = IDLE;
      end else begin
        row_d   = row_q + HW'(1);
        state_d = FIRST;
      end
    end

    if (emit) begin
      dout_vld_d = 1'b1;
      if (first_q) begin
        dout_start_d = 1'b1;
        first_d      = 1'b0;
      end
    end

    if (frame_start) begin
      h_last_d     = frame_h - HW'(1);
      w_last_d     = frame_w - WW'(1);
      s_last_d     = (scale == '0) ? '0 : scale - SW'(1);
      row_d        = '0;
      col_d        = '0;
      rep_d        = '0;
      pass_d       = '0;
      prime_d      = 1'b0;
      first_d      = 1'b1;
      dout_d       = dout_q;
      dout_vld_d   = 1'b0;
      dout_start_d = 1'b0;
      state_d      = (frame_h != '0 && frame_w != '0) ? FIRST : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      h_last_q     <= '0;
      w_last_q     <= '0;
      s_last_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rep_q        <= '0;
      pass_q       <= '0;
      prime_q      <= 1'b0;
      first_q      <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      dout_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_last_q     <= h_last_d;
      w_last_q     <= w_last_d;
      s_last_q     <= s_last_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rep_q        <= rep_d;
      pass_q       <= pass_d;
      prime_q      <= prime_d;
      first_q      <= first_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      dout_start_q <= dout_start_d;
    end
  end

  // An aborting frame_start suppresses the copy already registered for that cycle.
  assign dout_vld   = dout_vld_q && !(frame_start && state_q != IDLE);
  assign dout_start = dout_start_q && dout_vld;
  assign dout       = dout_q;

endmodule

// File: tb/tb_upsample_nn.sv
// Directed bench for upsample_nn (small geometry, 4 channels x 8 bits).
module tb_upsample_nn;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          din_vld = 1'b0;
  logic          din_rdy, dout_start, dout_vld;
  logic [3:0]    frame_h = '0;
  logic [3:0]    frame_w = '0;
  logic [2:0]    scale = '0;
  logic [PW-1:0] din = '0;
  logic [PW-1:0] dout;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [PW-1:0] got [$];
  logic          vlog [$];
  logic          rlog [$];
  int            starts, start_idx, n_acc;
  logic          fs_vld, acc;
  logic [PW-1:0] pix [16];

  always #5 clk = ~clk;

  upsample_nn #(
    .FRAME_H_MAX (8),
    .FRAME_W_MAX (8),
    .SCALE_MAX   (4),
    .DATA_WIDTH  (8),
    .CH_NUM      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_h     (frame_h),
    .frame_w     (frame_w),
    .scale       (scale),
    .frame_start (frame_start),
    .din_vld     (din_vld),
    .din_rdy     (din_rdy),
    .din         (din),
    .dout_start  (dout_start),
    .dout_vld    (dout_vld),
    .dout        (dout)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [63:0] pack_log(input logic q [$], input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n && i < q.size(); i++) r[i] = q[i];
    return r;
  endfunction

  // One cycle: drive inputs after the falling edge, then sample what the next rising edge sees.
  task automatic drive(input logic fs, input logic vld, input logic [PW-1:0] d);
    @(negedge clk);
    frame_start = fs;
    din_vld     = vld;
    din         = d;
    #1;
    vlog.push_back(dout_vld);
    rlog.push_back(din_rdy);
    if (dout_start) begin
      starts++;
      start_idx = got.size();
    end
    if (dout_vld) got.push_back(dout);
    acc = vld && din_rdy;
  endtask

  task automatic run(input int h, input int w, input int s, input bit toggle, input int ncyc);
    frame_h = 4'(h);
    frame_w = 4'(w);
    scale   = 3'(s);
    drive(1'b1, 1'b1, 32'hDEADBEEF);
    fs_vld = vlog[vlog.size()-1];
    got.delete();
    vlog.delete();
    rlog.delete();
    starts    = 0;
    start_idx = -1;
    n_acc     = 0;
    for (int i = 0; i < ncyc; i++) begin
      logic v;
      v = (n_acc < h * w) && (!toggle || (i % 2 == 0));
      drive(1'b0, v, v ? pix[n_acc] : '0);
      if (acc) n_acc++;
    end
  endtask

  task automatic check_frame(input string tag, input int h, input int w, input int s);
    int se, n;
    logic [PW-1:0] exp;
    se = (s == 0) ? 1 : s;
    n  = 0;
    check({tag, "_count"}, got.size(), h * w * se * se);
    check({tag, "_accepted"}, n_acc, h * w);
    check({tag, "_starts"}, starts, 1);
    check({tag, "_start_pos"}, start_idx, 0);
    for (int r = 0; r < h; r++)
      for (int p = 0; p < se; p++)
        for (int c = 0; c < w; c++)
          for (int k = 0; k < se; k++) begin
            exp = pix[r * w + c];
`ifdef UPSAMPLE_ZERO_FILL_EN
            if (p != 0 || k != 0) exp = '0;
`endif
            if (n < got.size()) check($sformatf("%s_px%0d", tag, n), got[n], exp);
            n++;
          end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pix[i] = 32'h01020304 + i * 32'h10101010;

    repeat (3) drive(1'b0, 1'b0, '0);
    check("rst_vld", dout_vld, 0);
    check("rst_start", dout_start, 0);
    check("rst_rdy", din_rdy, 0);
    check("rst_dout", dout, 0);
    reset = 1'b0;

    // 2x2 frame, scale 2: AABB AABB CCDD CCDD with one bubble before each replay
    run(2, 2, 2, 1'b0, 20);
    check_frame("t1", 2, 2, 2);
    check("t1_vld_pattern", pack_log(vlog, 20), 64'(20'b0111_1011_1111_1101_1110));
    check("t1_rdy_pattern", pack_log(rlog, 10), 64'(10'b10_0000_0101));

    run(3, 4, 1, 1'b0, 14);
    check_frame("t2", 3, 4, 1);
    check("t2_rdy", pack_log(rlog, 12), 64'hFFF);
    check("t2_latency", pack_log(vlog, 2), 64'b10);

    run(3, 4, 0, 1'b0, 14);
    check_frame("t2z", 3, 4, 0);
    check("t2z_rdy", pack_log(rlog, 12), 64'hFFF);
    check("t2z_latency", pack_log(vlog, 2), 64'b10);

    run(1, 3, 3, 1'b1, 34);
    check_frame("t3", 1, 3, 3);

    run(2, 3, 2, 1'b0, 3);
    pix[0] = 32'h5A5A5A5A;
    run(1, 1, 2, 1'b0, 8);
    check("t4_fs_gap", fs_vld, 0);
    check_frame("t4", 1, 1, 2);
    pix[0] = 32'h01020304;

    run(2, 2, 2, 1'b0, 6);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0);
    check("t5_rst_vld", dout_vld, 0);
    check("t5_rst_start", dout_start, 0);
    check("t5_rst_rdy", din_rdy, 0);
    check("t5_rst_dout", dout, 0);
    reset = 1'b0;
    got.delete();
    repeat (10) drive(1'b0, 1'b0, '0);
    check("t5_no_partial", got.size(), 0);

    run(2, 0, 2, 1'b0, 6);
    check("t5_w0_out", got.size(), 0);
    check("t5_w0_rdy", pack_log(rlog, 6), 0);
    check("t5_w0_accept", n_acc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
